// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 fixed-baud UART core with a one-byte receive buffer
module uart_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] data_out,
    output logic       rxrdy,
    input  logic       oen,
    input  logic [7:0] data_in,
    input  logic       wen,
    output logic       txrdy,
    output logic       overflow,
    output logic       framing_err
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_shift_q;
    logic        tx_q, tx_d;
    logic        txrdy_q, txrdy_d;
    logic        tx_accept;

    assign tx_accept = !wen && txrdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        if (tx_state_q == TX_IDLE) begin
            tx_cnt_d = '0;
            if (tx_accept) begin
                tx_state_d = TX_START;
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end else begin
            tx_cnt_d = '0;
            if (tx_state_q == TX_START) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
            end else if (tx_state_q == TX_DATA) begin
                if (tx_idx_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end else begin
                tx_state_d = TX_IDLE;
            end
        end
    end

    // tx and txrdy are registered, so the line lags the FSM by one cycle
    always_comb begin
        tx_d = 1'b1;
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[tx_idx_q];
            default:  tx_d = 1'b1;
        endcase
        txrdy_d = (tx_state_q == TX_IDLE) && !tx_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q       <= 1'b1;
            txrdy_q    <= 1'b1;
            tx_shift_q <= '0;
        end else begin
            tx_q    <= tx_d;
            txrdy_q <= txrdy_d;
            if (tx_accept) begin
                tx_shift_q <= data_in;
            end
        end
    end

    logic        rx_meta_q, rx_sync_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q;
    logic [7:0]  data_out_q;
    logic        rxrdy_q, overflow_q, framing_err_q;
    logic        rx_shift_en, rx_stop_done, rx_deliver, rx_ferr, rx_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_idx_d   = rx_idx_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rx_shift_en  = (rx_state_q == RX_DATA) && (rx_cnt_q == BIT_LAST);
        rx_stop_done = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
        rx_deliver   = rx_stop_done && rx_sync_q;
        rx_ferr      = rx_stop_done && !rx_sync_q;
        rx_read      = !oen && rxrdy_q;
    end

    // A read in the same cycle as a delivery frees the buffer for the new byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_q    <= '0;
            data_out_q    <= '0;
            rxrdy_q       <= 1'b0;
            overflow_q    <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            framing_err_q <= rx_ferr;
            if (rx_shift_en) begin
                rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            end
            if (rx_deliver) begin
                if (!rxrdy_q || rx_read) begin
                    data_out_q <= rx_shift_q;
                    rxrdy_q    <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (rx_read) begin
                rxrdy_q    <= 1'b0;
                overflow_q <= 1'b0;
            end
        end
    end

    assign tx          = tx_q;
    assign txrdy       = txrdy_q;
    assign data_out    = data_out_q;
    assign rxrdy       = rxrdy_q;
    assign overflow    = overflow_q;
    assign framing_err = framing_err_q;

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed bench for uart_core at 8 clocks per bit
`timescale 1ns/1ps
module tb_uart_core;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n, oen, wen, rx_drive, loop_en;
    logic [7:0] data_in, data_out;
    logic       rx_w, tx, rxrdy, txrdy, overflow, framing_err;
    int         n_cmp = 0;
    int         n_err = 0;
    int         fe_cnt = 0;

    assign rx_w = loop_en ? tx : rx_drive;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_w), .tx(tx),
        .data_out(data_out), .rxrdy(rxrdy), .oen(oen),
        .data_in(data_in), .wen(wen), .txrdy(txrdy),
        .overflow(overflow), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (framing_err === 1'b1) fe_cnt <= fe_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_txrdy();
        int t = 0;
        while (txrdy !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("txrdy_wait", {31'd0, txrdy}, 32'd1);
    endtask

    // Returns at the negedge right after the accepting clock edge
    task automatic write_byte(input logic [7:0] b);
        wait_txrdy();
        data_in = b;
        wen = 1'b0;
        @(negedge clk);
        wen = 1'b1;
    endtask

    task automatic tx_write_check(input logic [7:0] b, input string tag);
        logic [9:0] f;
        logic [7:0] s;
        int low;
        f = {1'b1, b, 1'b0};
        write_byte(b);
        chk({tag, "_latency"}, {31'd0, tx}, 32'd1);
        low = (txrdy === 1'b0) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                s[c] = tx;
                if (txrdy === 1'b0) low++;
            end
            chk($sformatf("%s_bit%0d", tag, i), {24'd0, s}, {24'd0, {8{f[i]}}});
        end
        @(negedge clk);
        chk({tag, "_txrdy_rise"}, {31'd0, txrdy}, 32'd1);
        chk({tag, "_txrdy_low"}, low, 32'd81);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_byte(output logic [7:0] b, input string tag);
        int t = 0;
        while (rxrdy !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rxrdy"}, {31'd0, rxrdy}, 32'd1);
        b = data_out;
        oen = 1'b0;
        @(negedge clk);
        oen = 1'b1;
        chk({tag, "_read_clear"}, {31'd0, rxrdy}, 32'd0);
    endtask

    initial begin
        logic [7:0] got;
        int fe_base;
        rst_n = 1'b0; oen = 1'b1; wen = 1'b1; data_in = 8'h00;
        rx_drive = 1'b1; loop_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_txrdy", {31'd0, txrdy}, 32'd1);
        chk("rst_rxrdy", {31'd0, rxrdy}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'h00);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_framing_err", {31'd0, framing_err}, 32'd0);

        tx_write_check(8'hA5, "txA5");

        send_frame(8'h3C, 1'b1);
        chk("rx3C_data", {24'd0, data_out}, 32'h3C);
        read_byte(got, "rx3C");
        chk("rx3C_got", {24'd0, got}, 32'h3C);
        chk("rx3C_overflow", {31'd0, overflow}, 32'd0);

        fe_base = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        chk("ferr_pulses", fe_cnt - fe_base, 32'd1);
        chk("ferr_rxrdy", {31'd0, rxrdy}, 32'd0);

        fe_base = fe_cnt;
        rx_drive = 1'b0;
        repeat (2) @(negedge clk);
        rx_drive = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_rxrdy", {31'd0, rxrdy}, 32'd0);
        chk("glitch_ferr", fe_cnt - fe_base, 32'd0);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("ovf_data", {24'd0, data_out}, 32'h11);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_rxrdy", {31'd0, rxrdy}, 32'd1);
        read_byte(got, "ovf");
        chk("ovf_got", {24'd0, got}, 32'h11);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        fe_base = fe_cnt;
        loop_en = 1'b1;
        write_byte(8'h00);
        write_byte(8'hFF);
        read_byte(got, "loop0");
        chk("loop0_got", {24'd0, got}, 32'h00);
        write_byte(8'h81);
        read_byte(got, "loop1");
        chk("loop1_got", {24'd0, got}, 32'hFF);
        read_byte(got, "loop2");
        chk("loop2_got", {24'd0, got}, 32'h81);
        chk("loop_overflow", {31'd0, overflow}, 32'd0);
        chk("loop_ferr", fe_cnt - fe_base, 32'd0);
        wait_txrdy();
        repeat (20) @(negedge clk);
        loop_en = 1'b0;

        write_byte(8'h00);
        repeat (44) @(negedge clk);
        chk("midrst_bit4", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_txrdy", {31'd0, txrdy}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_write_check(8'h5A, "tx5A");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Byte-wide UART core, 8N1, fixed baud, for the far side of the host byte interface used by `control_unit`: it serialises bytes written by the host onto `tx` and deserialises `rx` into a one-byte receive buffer read by the host. Receive-buffer ready/strobe and transmit ready/strobe follow the host's existing `rxrdy`/`oen`/`data_out` and `txrdy`/`wen`/`data_in` contract. It replaces the vendor UART in the top level, driving `rxrdy`, `txrdy` and `data_out`, and consuming `oen`, `wen` and `data_in`.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  serial input, asynchronous, idle high.
- `tx`  out  1  serial output, idle high.
- `data_out`  out  8  received byte, valid while `rxrdy`=1.
- `rxrdy`  out  1  receive buffer holds an unread byte.
- `oen`  in  1  active-low read strobe; one low cycle consumes the buffer.
- `data_in`  in  8  byte to transmit, sampled while `wen`=0.
- `wen`  in  1  active-low write strobe.
- `txrdy`  out  1  transmitter can accept a byte.
- `overflow`  out  1  sticky: a byte was dropped because the buffer was full.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- Frame: 1 start (0), 8 data LSB first, 1 stop (1); no parity.
- TX FSM: IDLE -> START -> DATA (8 bits, 3-bit index) -> STOP -> IDLE. One bit counter runs 0..CLKS_PER_BIT-1 per bit.
- TX accept: `wen`=0 and `txrdy`=1 latches `data_in` into a shift register. `txrdy` drops the next cycle and the FSM enters START.
- TX ignore: `wen`=0 while `txrdy`=0 is ignored, with no side effects.
- RX input: `rx` passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> STOP -> (WAIT_HIGH) -> IDLE.
  - IDLE -> START on a synchronised falling edge.
  - START: wait CLKS_PER_BIT/2 (integer divide), then sample. If the sample is 1, it is a false start: go to IDLE with no flags.
  - DATA: 8 samples spaced CLKS_PER_BIT, shifted in LSB first.
  - STOP: sample once after CLKS_PER_BIT. If 1: deliver the byte, go to IDLE. If 0: `framing_err` pulses one cycle, the byte is discarded, and the FSM goes to WAIT_HIGH until the synchronised `rx`=1, then IDLE.
- Delivery with `rxrdy`=0: `data_out` is loaded and `rxrdy` is set.
- Delivery with `rxrdy`=1 and `oen`=1: new byte dropped, `data_out` unchanged, `overflow` set.
- Read: `oen`=0 with `rxrdy`=1 clears `rxrdy` and `overflow` next cycle. `oen`=0 with `rxrdy`=0 has no effect.
- Simultaneous read and delivery (same cycle): the host reads the old byte, the new byte loads, `rxrdy` stays 1, `overflow` unchanged.
- TX and RX are fully independent. Loopback `tx`->`rx` is legal.

## Timing
- Reset values: `tx`=1, `txrdy`=1, `rxrdy`=0, `data_out`=0x00, `overflow`=0, `framing_err`=0; both FSMs in IDLE, counters 0. Reset is asynchronous, so asserting it mid-frame forces `tx` high immediately and aborts any RX frame.
- TX latency: `wen` sampled low at edge N -> `tx` falls after edge N+1. Each bit holds exactly CLKS_PER_BIT cycles. The frame is 10*CLKS_PER_BIT cycles.
- TX turnaround: `txrdy` rises the cycle after the last stop-bit cycle. Back-to-back writes produce contiguous frames with 1 gap cycle.
- RX sample points: start-bit sample at CLKS_PER_BIT/2 cycles after the synchronised edge (2 cycles after the pin edge). Data bit k is sampled CLKS_PER_BIT*(k+1) cycles after that; stop bit CLKS_PER_BIT*9.
- `rxrdy` rises the cycle after the stop-bit sample.
- `framing_err` is high for exactly one cycle, the cycle after the stop sample.
- `overflow` is set the cycle after the dropped delivery.
- Tolerance: baud mismatch up to ±3% must receive correctly.

## Test plan
- TX byte: CLKS_PER_BIT=8, reset, write 0xA5 -> `tx` = 0,1,0,1,0,0,1,0,1,1, each 8 cycles; `txrdy` low for 81 cycles then high.
- RX byte: drive frame 0x3C at 8 clk/bit -> `rxrdy`=1, `data_out`=0x3C; pulse `oen` low -> `rxrdy`=0 next cycle.
- Overflow: receive 0x11 then 0x22 without reading -> `data_out`=0x11, `overflow`=1. Read -> both clear.
- Framing/glitch: frame 0x55 with stop=0 -> one-cycle `framing_err`, `rxrdy` stays 0. A 2-cycle low glitch on `rx` -> no flags, no byte.
- Loopback: tie `tx` to `rx`, write 0x00, 0xFF, 0x81 back-to-back -> same three bytes read in order, no errors.
- Reset mid-frame: assert `rst_n`=0 during TX bit 4 -> `tx`=1 and `txrdy`=1 immediately. After release, write 0x5A -> correct frame.
